// File: rtl/sseg_scan_decoder.sv
// Decodes a multiplexed 4-digit active-low seven-segment bus back into hex nibbles and dp bits per digit.
// Optional scan-order checking is enabled with the SSEG_DEC_ORDER_CHECK_EN macro.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       code_err,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       r_s_an;
  logic [7:0]       r_s_seg;
  logic [3:0]       r_p_an;
  logic [7:0]       r_p_seg;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  state_t           r_state;
  state_t           w_state_next;

  logic             w_legal;
  logic [1:0]       w_idx;
  logic             w_same;
  logic             w_capture;
  logic [4:0]       w_dec;
  logic             w_cap_ok;
  logic             w_cap_bad;
  logic [3:0]       w_idx_onehot;
  logic [3:0]       w_valid_base;
  logic [3:0]       w_valid_set;

  logic [3:0]       r_digit_valid;
  logic             r_frame_done;
  logic             r_code_err;
  logic [3:0]       w_hex [4];
  logic [3:0]       w_dp;

  // Returns {legal, nibble}; patterns outside the table decode as illegal.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C;
      7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E;
      7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Both sample stages reset to the blanked value so the first post-reset sample always reads as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_an  <= 4'hF;
      r_s_seg <= 8'hFF;
      r_p_an  <= 4'hF;
      r_p_seg <= 8'hFF;
    end else begin
      r_s_an  <= an_in;
      r_s_seg <= sseg_in;
      r_p_an  <= r_s_an;
      r_p_seg <= r_s_seg;
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'd0;
    case (r_s_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_same = ({r_s_an, r_s_seg} == {r_p_an, r_p_seg});

  always_comb begin
    w_cnt_next = '0;
    if (w_same && w_legal) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_legal) begin
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!w_legal) begin
          w_state_next = ST_IDLE;
        end else if (w_cnt_next == CNT_MAX) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_same) begin
          w_state_next = w_legal ? ST_TRACK : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture fires on the single cycle TRACK sees the count reach its terminal value.
  always_comb begin
    w_capture = 1'b0;
    if (r_state == ST_TRACK && w_legal && w_cnt_next == CNT_MAX) begin
      w_capture = 1'b1;
    end
  end

  assign w_dec        = seg_decode(r_s_seg[6:0]);
  assign w_cap_ok     = w_capture && w_dec[4];
  assign w_cap_bad    = w_capture && !w_dec[4];
  assign w_idx_onehot = 4'b0001 << w_idx;
  assign w_valid_base = r_frame_done ? 4'b0000 : r_digit_valid;
  assign w_valid_set  = w_valid_base | w_idx_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit_valid <= 4'b0000;
      r_frame_done  <= 1'b0;
      r_code_err    <= 1'b0;
    end else begin
      r_code_err    <= w_cap_bad;
      r_frame_done  <= w_cap_ok && (w_valid_set == 4'hF);
      r_digit_valid <= w_cap_ok ? w_valid_set : w_valid_base;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] r_hex;
      logic       r_dp;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_hex <= 4'h0;
          r_dp  <= 1'b0;
        end else if (w_cap_ok && w_idx_onehot[gi]) begin
          r_hex <= w_dec[3:0];
          r_dp  <= r_s_seg[7];
        end
      end

      assign w_hex[gi] = r_hex;
      assign w_dp[gi]  = r_dp;
    end
  endgenerate

`ifdef SSEG_DEC_ORDER_CHECK_EN
  logic [1:0] r_last_idx;
  logic       r_seen;
  logic       r_seq_err;

  // Bad-code captures still advance the order tracker, so a corrupted digit does not cascade errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_idx <= 2'd0;
      r_seen     <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_seq_err <= w_capture && r_seen && (w_idx != r_last_idx + 2'd1);
      if (w_capture) begin
        r_last_idx <= w_idx;
        r_seen     <= 1'b1;
      end
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

  assign hex0        = w_hex[0];
  assign hex1        = w_hex[1];
  assign hex2        = w_hex[2];
  assign hex3        = w_hex[3];
  assign dp_out      = w_dp;
  assign digit_valid = r_digit_valid;
  assign frame_done  = r_frame_done;
  assign code_err    = r_code_err;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder with STABLE_CYCLES=4; expected captures are queued when a slot is driven.
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] an_in = 4'hF;
  logic [7:0] sseg_in = 8'hFF;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dp_out;
  logic [3:0] digit_valid;
  logic       frame_done, code_err, seq_err;

  sseg_scan_decoder #(
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .an_in(an_in),
    .sseg_in(sseg_in),
    .hex3(hex3),
    .hex2(hex2),
    .hex1(hex1),
    .hex0(hex0),
    .dp_out(dp_out),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .code_err(code_err),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

`ifdef SSEG_DEC_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  typedef struct {
    int       cyc;
    int       d;
    bit       bad;
    logic [3:0] nib;
    logic     dp;
  } ev_t;

  ev_t        q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [3:0] exp_hex [4];
  logic [3:0] exp_dp = 4'h0;
  logic [3:0] exp_valid = 4'h0;
  logic       exp_fd, exp_ce, exp_se;
  bit         clr_pending = 1'b0;
  bit         seen = 1'b0;
  int         last = 0;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue a capture expected STABLE_CYCLES edges after the first sample of the currently driven inputs.
  task automatic expect_capture(input logic [3:0] an, input logic [7:0] seg, input bit bad, input logic [3:0] nib);
    ev_t ev;
    ev.cyc = cyc + 5;
    ev.bad = bad;
    ev.nib = nib;
    ev.dp  = seg[7];
    case (an)
      4'b1110: ev.d = 0;
      4'b1101: ev.d = 1;
      4'b1011: ev.d = 2;
      default: ev.d = 3;
    endcase
    q.push_back(ev);
  endtask

  task automatic tick();
    ev_t ev;
    logic [3:0] nv;
    @(posedge clk);
    #1;
    cyc++;
    exp_fd = 1'b0;
    exp_ce = 1'b0;
    exp_se = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) exp_hex[i] = 4'h0;
      exp_dp = 4'h0;
      exp_valid = 4'h0;
      clr_pending = 1'b0;
      seen = 1'b0;
      q.delete();
    end else begin
      if (clr_pending) begin
        exp_valid = 4'h0;
        clr_pending = 1'b0;
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        exp_se = ORDER_EN && seen && (ev.d != ((last + 1) % 4));
        last = ev.d;
        seen = 1'b1;
        if (ev.bad) begin
          exp_ce = 1'b1;
        end else begin
          exp_hex[ev.d] = ev.nib;
          exp_dp[ev.d] = ev.dp;
          nv = exp_valid | (4'b0001 << ev.d);
          if (nv == 4'hF) begin
            exp_fd = 1'b1;
            clr_pending = 1'b1;
          end
          exp_valid = nv;
        end
        $display("cycle %0d: capture digit=%0d bad=%0b nib=%h dp=%0b frame=%0b seq=%0b",
                 cyc, ev.d, ev.bad, ev.nib, ev.dp, exp_fd, exp_se);
      end
    end
    chk("frame_done", 16'(frame_done), 16'(exp_fd));
    chk("code_err", 16'(code_err), 16'(exp_ce));
    chk("seq_err", 16'(seq_err), 16'(exp_se));
    chk("digit_valid", 16'(digit_valid), 16'(exp_valid));
    chk("dp_out", 16'(dp_out), 16'(exp_dp));
    chk("hex", {hex3, hex2, hex1, hex0}, {exp_hex[3], exp_hex[2], exp_hex[1], exp_hex[0]});
  endtask

  task automatic slot(input logic [3:0] an, input logic [7:0] seg, input int n, input bit bad, input logic [3:0] nib);
    an_in = an;
    sseg_in = seg;
    if (n >= 4 && $countones(~an) == 1) expect_capture(an, seg, bad, nib);
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_hex[i] = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // Settled scan of a single digit with dp bit set
    slot(4'b1110, {1'b1, pat(4'h3)}, 6, 1'b0, 4'h3);
    // Full frame 1,2,A,F
    slot(4'b1110, {1'b0, pat(4'h1)}, 6, 1'b0, 4'h1);
    slot(4'b1101, {1'b0, pat(4'h2)}, 6, 1'b0, 4'h2);
    slot(4'b1011, {1'b0, pat(4'hA)}, 6, 1'b0, 4'hA);
    slot(4'b0111, {1'b0, pat(4'hF)}, 6, 1'b0, 4'hF);
    slot(4'hF, 8'hFF, 2, 1'b0, 4'h0);
    // Glitch shorter than the settle window
    slot(4'b1101, 8'h00, 3, 1'b0, 4'h0);
    slot(4'hF, 8'hFF, 4, 1'b0, 4'h0);
    // Undecodable pattern
    slot(4'b1011, 8'b01111111, 6, 1'b1, 4'h0);
    slot(4'hF, 8'hFF, 2, 1'b0, 4'h0);
    // Reset after two stable samples
    an_in = 4'b1110;
    sseg_in = {1'b1, pat(4'h5)};
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_capture(4'b1110, {1'b1, pat(4'h5)}, 1'b0, 4'h5);
    repeat (6) tick();
    // Segment change on a constant digit restarts the count
    slot(4'b0111, {1'b0, pat(4'h5)}, 2, 1'b0, 4'h5);
    slot(4'b0111, {1'b1, pat(4'h6)}, 6, 1'b0, 4'h6);
    // Long hold must not recapture
    slot(4'b1101, {1'b0, pat(4'h8)}, 20, 1'b0, 4'h8);
    // Out-of-order pair 0 then 2, completing a frame
    slot(4'b1110, {1'b0, pat(4'h0)}, 6, 1'b0, 4'h0);
    slot(4'b1011, {1'b1, pat(4'h9)}, 6, 1'b0, 4'h9);
    slot(4'hF, 8'hFF, 3, 1'b0, 4'h0);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receiver for the multiplexed four-digit seven-segment bus driven by the display scanner. It samples the active-low digit enables and segment lines, waits for each scan slot to settle, and decodes the segment pattern back into a hex nibble and decimal point per digit. It also flags illegal patterns and reports each completed four-digit frame. It serves as a bench monitor and as an on-board loop-back checker for the display path.

## Interface
- STABLE_CYCLES, 16: number of consecutive identical registered samples required before a slot is captured (legal range 2..255).
- CNT_W, 8: width of the stability counter; must hold STABLE_CYCLES-1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- an_in  in  4  digit enables, active low, one-hot-zero (1110 = digit 0 … 0111 = digit 3).
- sseg_in  in  8  bit 7 = dp; bits 6..0 = segments a..g, active low, a in bit 6.
- hex3, hex2, hex1, hex0  out  4 each  last decoded nibble per digit.
- dp_out  out  4  last captured dp per digit (bit i = digit i).
- digit_valid  out  4  bit i set once digit i has been captured since the last frame_done or reset.
- frame_done  out  1  one-cycle pulse when all four digits have been captured.
- code_err  out  1  one-cycle pulse when a settled slot carries an undecodable pattern.
- seq_err  out  1  one-cycle pulse on an out-of-order capture; see Configuration.

## Operation
- Input stage: an_in and sseg_in are registered once into s_an and s_seg. All logic below uses the registered values.
- A slot is legal when s_an has exactly one zero bit. The index of the zero bit is the digit index. Any other s_an value is idle or blanked.
- Stability counter: clears to 0 when {s_an, s_seg} differs from the previous registered sample, or when the slot is not legal. Otherwise it increments and saturates at STABLE_CYCLES-1.
- FSM states:
  - IDLE: slot not legal. Go to TRACK when the slot becomes legal.
  - TRACK: counting. When the counter reaches STABLE_CYCLES-1, perform a capture and go to HOLD.
  - HOLD: captured and waiting. Go to TRACK on any change of {s_an, s_seg} to a legal slot. Go to IDLE on a change to an illegal slot.
- A capture happens exactly once per settled slot. Glitches shorter than STABLE_CYCLES samples never capture.
- Capture, for digit index i:
  - Decode s_seg[6:0] with the fixed table:
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110
    - 4=1001100, 5=0100100, 6=0100000, 7=0001111
    - 8=0000000, 9=0000100, A=0001000, b=1100000
    - C=0110001, d=1000010, E=0110000, F=0111000
  - Legal pattern: write hex_i, write dp_out[i] = s_seg[7], set digit_valid[i].
  - Any other pattern: pulse code_err. hex_i, dp_out[i] and digit_valid[i] are unchanged.
- Frame tracking:
  - When a capture would make digit_valid equal 1111, pulse frame_done in that same update.
  - digit_valid clears to 0000 on the following cycle.
  - Recapturing an already-valid digit overwrites hex_i and dp_out[i] and leaves the mask unchanged.

## Timing
- Reset values: hex0..hex3 = 0, dp_out = 0, digit_valid = 0, frame_done = 0, code_err = 0, seq_err = 0, FSM = IDLE, counter = 0.
- Reset has priority over every other event, including a capture in the same cycle.
- Latency: inputs held constant from before edge t0 produce their first registered sample at t0. Outputs update at edge t0 + STABLE_CYCLES.
- frame_done, code_err and seq_err are registered, last exactly one cycle and are never stretched.
- A reset asserted mid-slot discards any partial count. Capture requires STABLE_CYCLES fresh samples after reset deasserts.
- A change in sseg_in with an_in constant restarts the count. The slot can capture again with the new value.
- Counter saturation: HOLD may last indefinitely without recapture.

## Configuration
- SSEG_DEC_ORDER_CHECK_EN defined:
  - Tracks the index of the last captured digit.
  - Each capture (legal or code_err) whose index is not (last+1) mod 4 pulses seq_err.
  - The first capture after reset is not checked.
- Not defined: seq_err is tied to 0 and no order state exists.

## Test plan
- Settled scan (STABLE_CYCLES=4): hold an_in=1110, sseg_in=10000110 for 6 cycles -> hex0=3, dp_out[0]=1, digit_valid=0001 at edge t0+4.
- Full frame: scan digits 0..3 with patterns for 1, 2, A, F, each held 6 cycles -> frame_done pulses once with hex3..0 = F,A,2,1; digit_valid is 0000 the next cycle.
- Glitch: an_in=1101 with sseg_in=00000000 for 3 cycles, then an_in=1111 -> no capture, digit_valid unchanged, no error pulses.
- Bad code: an_in=1011, sseg_in=01111111 for 6 cycles -> single code_err pulse; hex2 and digit_valid[2] unchanged.
- Reset mid-slot: reset pulses after 2 stable samples -> all outputs 0; capture occurs 4 edges after the first post-reset sample.
- With SSEG_DEC_ORDER_CHECK_EN: capture digit 0, then digit 2 -> seq_err pulses once on the digit 2 capture.
